// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM duty-cycle fade sequencer and its period counter.
package pwm_fade_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } fade_state_e;

    localparam int unsigned DEF_R      = 8;
    localparam int unsigned DEF_HOLD_W = 8;
    localparam int unsigned PERIOD_LEN = 2 ** DEF_R;

    function automatic int unsigned period_len(input int unsigned r);
        return 32'd1 << r;
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running R-bit PWM period counter; tick_o is high during the last count of each period.
module pwm_period_tick
    import pwm_fade_pkg::*;
#(
    parameter int unsigned R = DEF_R
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned   PLEN     = period_len(R);
    localparam logic [R-1:0]  PRE_WRAP = R'(PLEN - 2);
    localparam logic [R-1:0]  CNT_ONE  = R'(1);

    logic [R-1:0] cnt_q;
    logic         tick_q;

    // Tick is registered one count early so it lines up with count == 2**R-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= {R{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            tick_q <= (cnt_q == PRE_WRAP);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle ramp sequencer feeding a PWM generator; ciclo only changes at period boundaries.
// Optional retrigger during a ramp is enabled by defining PWM_FADE_RETRIG_EN.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int unsigned R      = DEF_R,
    parameter int unsigned HOLD_W = DEF_HOLD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [R-1:0]      cmd_target,
    input  logic [R-1:0]      cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic [R-1:0]      ciclo,
    output logic              period_tick,
    output logic              busy,
    output logic              done
);

    localparam logic [R-1:0]      STEP_ONE = R'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    fade_state_e       state_q;
    logic [R-1:0]      ciclo_q;
    logic [R-1:0]      target_q;
    logic [R-1:0]      step_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic              tick_s;
    logic              accept_s;
    logic              up_s;
    logic              hold_hit_s;
    logic [R:0]        diff_s;
    logic [R:0]        delta_s;
    logic [R:0]        sum_s;
    logic [R-1:0]      ciclo_d;
    logic [R-1:0]      step_nz_s;
    logic [HOLD_W-1:0] hold_nz_s;

    pwm_period_tick #(.R(R)) u_period (
        .clk_i  (clk),
        .rst_i  (reset),
        .tick_o (tick_s)
    );

`ifdef PWM_FADE_RETRIG_EN
    assign cmd_ready = 1'b1;
`else
    assign cmd_ready = (state_q == ST_IDLE);
`endif
    assign accept_s = cmd_valid & cmd_ready;

    // Next step value: move by min(step, distance) so the target is never overshot.
    always_comb begin
        up_s = (target_q > ciclo_q);
        if (up_s) begin
            diff_s = {1'b0, target_q} - {1'b0, ciclo_q};
        end else begin
            diff_s = {1'b0, ciclo_q} - {1'b0, target_q};
        end
        if ({1'b0, step_q} < diff_s) begin
            delta_s = {1'b0, step_q};
        end else begin
            delta_s = diff_s;
        end
        if (up_s) begin
            sum_s = {1'b0, ciclo_q} + delta_s;
        end else begin
            sum_s = {1'b0, ciclo_q} - delta_s;
        end
        if (sum_s[R]) begin
            ciclo_d = up_s ? {R{1'b1}} : {R{1'b0}};
        end else begin
            ciclo_d = sum_s[R-1:0];
        end
        hold_hit_s = (({1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1}) == {1'b0, hold_q});
        step_nz_s  = (cmd_step == {R{1'b0}})      ? STEP_ONE : cmd_step;
        hold_nz_s  = (cmd_hold == {HOLD_W{1'b0}}) ? HOLD_ONE : cmd_hold;
    end

    // Command acceptance and ramp sequencing; a command always wins over a same-cycle tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ciclo_q    <= {R{1'b0}};
            target_q   <= {R{1'b0}};
            step_q     <= STEP_ONE;
            hold_q     <= HOLD_ONE;
            hold_cnt_q <= {HOLD_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        target_q   <= cmd_target;
                        step_q     <= step_nz_s;
                        hold_q     <= hold_nz_s;
                        hold_cnt_q <= {HOLD_W{1'b0}};
                        if (cmd_target == ciclo_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RAMP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
`ifdef PWM_FADE_RETRIG_EN
                    if (accept_s) begin
                        target_q   <= cmd_target;
                        step_q     <= step_nz_s;
                        hold_q     <= hold_nz_s;
                        hold_cnt_q <= {HOLD_W{1'b0}};
                        if (cmd_target == ciclo_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else
`endif
                    if (tick_s) begin
                        if (hold_hit_s) begin
                            ciclo_q    <= ciclo_d;
                            hold_cnt_q <= {HOLD_W{1'b0}};
                            if (ciclo_d == target_q) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ciclo       = ciclo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign period_tick = tick_s;

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Duty-cycle sequencer for the basic R-bit PWM generator.
- Accepts ramp commands (target duty, step size, hold time) over a valid/ready handshake.
- Drives the PWM `ciclo` input, moving it toward the target by a fixed step.
- Updates `ciclo` only at PWM period boundaries, so every period has a single, glitch-free duty value.
- Sits between a host/FSM (LED breathing, motor soft-start) and the PWM instance.

Parameters:
- R, 8: PWM resolution in bits. Width of the duty value and of the period counter. PWM period is 2**R clocks.
- HOLD_W, 8: width of the hold field, in PWM periods per step.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: command can be accepted this cycle.
- cmd_target, input, R: final duty value.
- cmd_step, input, R: duty increment or decrement per step. 0 is treated as 1.
- cmd_hold, input, HOLD_W: PWM periods between steps. 0 is treated as 1.
- ciclo, output, R: duty value to the PWM generator.
- period_tick, output, 1: high for one clock at the last count of each PWM period.
- busy, output, 1: ramp in progress.
- done, output, 1: one-cycle pulse when `ciclo` reaches the target.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - ciclo=0, busy=0, done=0, period counter=0, period_tick=0, state=IDLE.
  - cmd_ready=1 once reset is released.
- Period counter:
  - R-bit, free-running, wraps from 2**R-1 to 0.
  - period_tick = (count == 2**R-1), registered-equivalent timing.
  - Phase matches a PWM counter released from reset on the same edge.
- Handshake:
  - A command transfers on the rising edge where cmd_valid & cmd_ready.
  - cmd_ready = (state == IDLE).
  - cmd_valid while not ready is ignored; nothing is queued.
- States:
  - IDLE: on transfer, latch target, step (0 becomes 1) and hold (0 becomes 1); clear hold_cnt.
    - If target == ciclo: stay in IDLE; done=1 in the next cycle.
    - Otherwise go to RAMP with busy=1.
  - RAMP: on each period_tick, hold_cnt increments.
    - When hold_cnt+1 == hold, take a step and clear hold_cnt.
    - Step: ciclo <= ciclo ± min(step, |target − ciclo|).
    - Compute in R+1 bits. No overshoot, no wrap past 0 or 2**R-1.
    - If the new ciclo == target: go to IDLE with busy=0 and done=1 in the cycle ciclo first shows the target.
- A period_tick in the same cycle as command acceptance is not counted.
  - The first step happens at the hold-th tick strictly after acceptance.
- done is high for exactly one clock per completed command.
- busy and done are never high together.
- Reset during RAMP: ramp is abandoned, ciclo=0 immediately, no done.

Optional Feature:
Macro `PWM_FADE_RETRIG_EN`.
- Defined:
  - cmd_ready=1 in all states.
  - A command accepted during RAMP replaces target, step and hold, and clears hold_cnt.
  - The ramp continues from the current ciclo. The replaced command produces no done.
  - If the new target == ciclo, go to IDLE with a done pulse next cycle.
- Undefined: cmd_ready=0 during RAMP, as described under Behaviour.

Decomposition:
- Shared header/package `pwm_fade_pkg` holds:
  - state encodings (IDLE, RAMP);
  - default R and HOLD_W;
  - the localparam for the period length, 2**R.
- One natural sub-module: `pwm_period_tick`, the R-bit wrap counter producing period_tick.
  - The PWM generator can share it so both stay phase-aligned.
- The step/saturation arithmetic stays inline.

Test Plan:
All scenarios use R=8, so one period is 256 clocks.
1. Reset check: assert reset mid-clock, then release → ciclo=0, busy=0, done=0, cmd_ready=1. period_tick first high at clock 255 after release, then every 256 clocks.
2. Up-ramp: from ciclo=0, send target=64, step=16, hold=1 → ciclo goes 16, 32, 48, 64 on four consecutive ticks. done pulses once, in the cycle ciclo=64. busy is high from the cycle after acceptance until done.
3. Down-ramp, non-multiple step: from 64, send target=10, step=20, hold=2 → ciclo goes 44, 24, 10, one step every 512 clocks, never below 10. done after 10.
4. Degenerate inputs:
   - From 10, send target=10 → done next cycle, busy stays 0.
   - From 0, send target=255, step=0, hold=0 → +1 per period, reaching 255 after 255 ticks.
   - From 0, send target=255, step=255 → ciclo=255 in one step.
5. Command during ramp:
   - Without the macro: cmd_ready=0 and the second command has no effect.
   - With `PWM_FADE_RETRIG_EN`: mid-ramp at ciclo=32, send target=0, step=8 → ciclo goes 24, 16, 8, 0, with a single done.
6. Reset mid-ramp: during scenario 2, after ciclo=32, assert reset → ciclo=0 in the same cycle, no done. After release, a new command works normally.
